// File: rtl/cnn_tile_streamer_if.sv
// Byte-stream handshake bundle for cnn_tile_streamer: input stream and result stream.
// master = the RISC-V side driving bytes in and consuming results; slave = the streamer.
interface cnn_tile_streamer_if #(
  parameter int DW = 8
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/cnn_tile_streamer.sv
// Loads 9 kernel + 16 tile bytes, holds them for the conv engine, streams the 4 results out.
// Latency: last tile byte at edge N -> results captured and out_valid at edge N+1+COMPUTE_WAIT.
// Backpressure: in_ready=0 until all results drain; out_data holds while out_ready=0. Macro CNN_STREAM_OUT_LAST_EN adds out_last/frame_done.
module cnn_tile_streamer #(
  parameter int DW           = 8,
  parameter int COMPUTE_WAIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  cnn_tile_streamer_if.slave  bus,
  input  logic                ker_reload,
  output logic [16*DW-1:0]    tile_flat,
  output logic [9*DW-1:0]     ker_flat,
  input  logic [4*DW-1:0]     conv_res,
  output logic                busy
`ifdef CNN_STREAM_OUT_LAST_EN
  ,
  output logic                out_last,
  output logic                frame_done
`endif
);

  typedef enum logic [1:0] {LOAD_KER, LOAD_TILE, COMPUTE, DRAIN} state_t;

  localparam int WW = $clog2(COMPUTE_WAIT + 1);

  state_t               state;
  logic [3:0]           cnt;
  logic [WW-1:0]        wcnt;
  logic [1:0]           idx;
  logic                 ker_loaded;
  logic [8:0][DW-1:0]   ker_r;
  logic [15:0][DW-1:0]  tile_r;
  logic [3:0][DW-1:0]   res;
  logic                 in_hs;
  logic                 out_hs;

  assign in_hs     = bus.in_valid && bus.in_ready;
  assign out_hs    = bus.out_valid && bus.out_ready;
  assign ker_flat  = ker_r;
  assign tile_flat = tile_r;
  assign busy      = !(((state == LOAD_KER) || (state == LOAD_TILE)) && (cnt == 4'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOAD_KER;
      cnt           <= '0;
      wcnt          <= '0;
      idx           <= '0;
      ker_loaded    <= 1'b0;
      ker_r         <= '0;
      tile_r        <= '0;
      res           <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
`ifdef CNN_STREAM_OUT_LAST_EN
      out_last      <= 1'b0;
      frame_done    <= 1'b0;
`endif
    end else begin
`ifdef CNN_STREAM_OUT_LAST_EN
      frame_done <= 1'b0;
`endif
      case (state)
        LOAD_KER: begin
          bus.in_ready <= 1'b1;
          if (in_hs) begin
            ker_r[cnt] <= bus.in_data;
            if (cnt == 4'd8) begin
              ker_loaded <= 1'b1;
              cnt        <= '0;
              state      <= LOAD_TILE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        LOAD_TILE: begin
          bus.in_ready <= 1'b1;
          if (in_hs) begin
            tile_r[cnt] <= bus.in_data;
            if (cnt == 4'd15) begin
              cnt          <= '0;
              wcnt         <= '0;
              bus.in_ready <= 1'b0;
              state        <= COMPUTE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        COMPUTE: begin
          // engine inputs have been stable for the full settle window once wcnt reaches the limit
          if (wcnt == WW'(COMPUTE_WAIT)) begin
            res           <= conv_res;
            bus.out_data  <= conv_res[DW-1:0];
            bus.out_valid <= 1'b1;
            idx           <= '0;
            wcnt          <= '0;
            state         <= DRAIN;
`ifdef CNN_STREAM_OUT_LAST_EN
            out_last      <= 1'b0;
`endif
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (idx == 2'd3) begin
              bus.out_valid <= 1'b0;
              bus.out_data  <= '0;
              idx           <= '0;
              bus.in_ready  <= 1'b1;
              state         <= (ker_reload || !ker_loaded) ? LOAD_KER : LOAD_TILE;
`ifdef CNN_STREAM_OUT_LAST_EN
              out_last      <= 1'b0;
              frame_done    <= 1'b1;
`endif
            end else begin
              idx          <= idx + 2'd1;
              bus.out_data <= res[idx + 2'd1];
`ifdef CNN_STREAM_OUT_LAST_EN
              out_last     <= (idx == 2'd2);
`endif
            end
          end
        end
        default: state <= LOAD_KER;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_tile_streamer.sv
// Bench for cnn_tile_streamer: models the combinational conv engine and checks streamed results.
module tb_cnn_tile_streamer;

  logic         clk;
  logic         rst_n;
  logic         ker_reload;
  logic         busy;
  logic [127:0] tile_flat;
  logic [71:0]  ker_flat;
  logic [31:0]  conv_res;
`ifdef CNN_STREAM_OUT_LAST_EN
  logic         out_last;
  logic         frame_done;
`endif

  cnn_tile_streamer_if #(.DW(8)) bus ();

  cnn_tile_streamer #(.DW(8), .COMPUTE_WAIT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ker_reload (ker_reload),
    .tile_flat  (tile_flat),
    .ker_flat   (ker_flat),
    .conv_res   (conv_res),
    .busy       (busy)
`ifdef CNN_STREAM_OUT_LAST_EN
    ,
    .out_last   (out_last),
    .frame_done (frame_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit need_ker;
  bit gaps_en;
  logic [7:0] ker_m [9];
  logic [7:0] tile_m [16];

  // Engine stand-in: 3x3 correlation over the 4x4 tile, four 8-bit truncated outputs.
  function automatic logic [31:0] engine(input logic [127:0] t, input logic [71:0] k);
    logic [31:0] r;
    int acc;
    r = '0;
    for (int o = 0; o < 4; o++) begin
      acc = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          acc += int'(t[8*(4*(o/2+i)+(o%2)+j) +: 8]) * int'(k[8*(3*i+j) +: 8]);
      r[8*o +: 8] = acc[7:0];
    end
    return r;
  endfunction

  assign conv_res = engine(tile_flat, ker_flat);

  // Reference: window centred on tile (orow, ocol+1), 0-based, modulo 256.
  function automatic logic [7:0] ref_out(input int orow, input int ocol);
    int s;
    s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += int'(tile_m[4*(orow+dr) + ocol + 1 + dc]) * int'(ker_m[3*(dr+1) + dc + 1]);
    return 8'(s % 256);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gaps_en && $urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", n < 50, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input logic [31:0] exp, input logic [3:0] rdy);
    int got, cyc, pi, fd;
    logic [7:0] held;
    bit stalled;
    got = 0; cyc = 0; pi = 0; fd = 0; stalled = 0; held = '0;
    while (got < 4 && cyc < 200) begin
      bus.out_ready = rdy[pi % 4];
      pi++;
`ifdef CNN_STREAM_OUT_LAST_EN
      fd += int'(frame_done);
`endif
      if (bus.out_valid === 1'b1) begin
        check("in_ready_drain", bus.in_ready, 1'b0);
`ifdef CNN_STREAM_OUT_LAST_EN
        check("out_last", out_last, got == 3);
`endif
        if (stalled) check("stall_hold", bus.out_data, held);
        if (bus.out_ready) begin
          check($sformatf("out_byte%0d", got), bus.out_data, exp[8*got +: 8]);
          got++;
          stalled = 0;
        end else begin
          held    = bus.out_data;
          stalled = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    check("drain_count", got, 4);
    check("out_valid_after", bus.out_valid, 1'b0);
`ifdef CNN_STREAM_OUT_LAST_EN
    fd += int'(frame_done);
    @(negedge clk);
    fd += int'(frame_done);
    check("frame_done_once", fd, 1);
`endif
  endtask

  task automatic run_frame(input logic [3:0] rdy, input bit reload_next, input logic [31:0] exp);
    logic [127:0] tp;
    logic [71:0]  kp;
    if (need_ker) begin
      for (int k = 0; k < 9; k++) begin
        send_byte(ker_m[k]);
        if (k == 0) check("busy_loading", busy, 1'b1);
      end
    end
    for (int t = 0; t < 16; t++) send_byte(tile_m[t]);
    for (int k = 0; k < 9; k++) kp[8*k +: 8] = ker_m[k];
    for (int t = 0; t < 16; t++) tp[8*t +: 8] = tile_m[t];
    check("ker_flat", ker_flat, kp);
    check("tile_flat", tile_flat, tp);
    check("in_ready_compute", bus.in_ready, 1'b0);
    check("busy_compute", busy, 1'b1);
    check("out_valid_n", bus.out_valid, 1'b0);
    ker_reload = reload_next;
    @(negedge clk);
    check("out_valid_n1", bus.out_valid, 1'b0);
    @(negedge clk);
    check("out_valid_n2", bus.out_valid, 1'b1);
    drain(exp, rdy);
    need_ker = reload_next;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_data"}, bus.out_data, 8'h00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_tile_flat"}, tile_flat, 128'h0);
    check({tag, "_ker_flat"}, ker_flat, 72'h0);
`ifdef CNN_STREAM_OUT_LAST_EN
    check({tag, "_out_last"}, out_last, 1'b0);
    check({tag, "_frame_done"}, frame_done, 1'b0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [71:0] kp;
    logic [31:0] exp;
    logic [3:0]  rdy;
    bit          rl;

    rst_n = 1'b0; ker_reload = 1'b0; gaps_en = 0; need_ker = 1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    #1 check("in_ready_before_edge", bus.in_ready, 1'b0);
    @(negedge clk);
    check("in_ready_after_edge", bus.in_ready, 1'b1);
    check("busy_idle", busy, 1'b0);

    // Kernel all ones, tile 1..16.
    for (int k = 0; k < 9; k++) ker_m[k] = 8'd1;
    for (int t = 0; t < 16; t++) tile_m[t] = 8'(t + 1);
    run_frame(4'b1111, 1'b1, 32'h635A3F36);

    // Centre-only kernel, stalled drain, then kernel retained for tile 17..32.
    for (int k = 0; k < 9; k++) ker_m[k] = (k == 4) ? 8'd1 : 8'd0;
    run_frame(4'b1001, 1'b0, 32'h0B0A0706);
    for (int t = 0; t < 16; t++) tile_m[t] = 8'(t + 17);
    run_frame(4'b1111, 1'b1, 32'h1B1A1716);

    // Saturating inputs wrap modulo 256.
    for (int k = 0; k < 9; k++) ker_m[k] = 8'hFF;
    for (int t = 0; t < 16; t++) tile_m[t] = 8'hFF;
    run_frame(4'b1011, 1'b0, 32'h09090909);

    // Reset part-way through a tile load.
    for (int t = 0; t < 8; t++) send_byte(8'(t + 100));
    rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    need_ker = 1;
    @(negedge clk);
    for (int k = 0; k < 9; k++) ker_m[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 9; k++) send_byte(ker_m[k]);
    for (int k = 0; k < 9; k++) kp[8*k +: 8] = ker_m[k];
    check("reload_ker_flat", ker_flat, kp);
    check("reload_tile_clear", tile_flat, 128'h0);
    need_ker = 0;
    for (int t = 0; t < 16; t++) tile_m[t] = 8'($urandom_range(0, 255));
    exp = {ref_out(2, 1), ref_out(2, 0), ref_out(1, 1), ref_out(1, 0)};
    run_frame(4'b1111, 1'b0, exp);

    // Random frames with input gaps and random backpressure.
    gaps_en = 1;
    for (int f = 0; f < 8; f++) begin
      if (need_ker)
        for (int k = 0; k < 9; k++) ker_m[k] = 8'($urandom_range(0, 255));
      for (int t = 0; t < 16; t++) tile_m[t] = 8'($urandom_range(0, 255));
      exp = {ref_out(2, 1), ref_out(2, 0), ref_out(1, 1), ref_out(1, 0)};
      rdy = 4'($urandom_range(0, 15)) | 4'b0001;
      rl  = 1'($urandom_range(0, 1));
      run_frame(rdy, rl, exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnn_tile_streamer.md
Name: cnn_tile_streamer

Overview:
Front/back-end sequencer for the combinational 3x3-kernel / 4x4-tile convolution engine.
- Accepts a serial byte stream (kernel, then tile) and holds it in registers.
- Presents the tile and kernel as flat buses to the engine.
- Captures the four 8-bit results and streams them back out serially with valid/ready.
- Turns the engine's parallel combinational interface into a streaming interface for the RISC-V side.

Parameters:
- DW, 8: data byte width. Must be 8 to match the engine.
- COMPUTE_WAIT, 1: cycles (>=1) the tile and kernel are held stable before results are captured.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. Asynchronous assert, active-low.
- in_data  input  DW  stream byte (kernel or tile).
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- ker_reload  input  1  sampled at frame end. 1 = next frame begins with 9 kernel bytes.
- tile_flat  output  16*DW  tile to engine; byte [8*(4r+c)+:8] = row r+1, col c (r,c 0-based).
- ker_flat  output  9*DW  kernel to engine; byte [8*(3r+c)+:8] = kernel row r+1, col c.
- conv_res  input  4*DW  engine results: [7:0]=out10, [15:8]=out11, [23:16]=out20, [31:24]=out21.
- out_data  output  DW  result byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- busy  output  1  high in every state except LOAD_KER/LOAD_TILE with byte count 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD_KER; byte count=0; wait counter=0; out index=0; ker_loaded=0.
  - tile_flat=0, ker_flat=0, result regs=0.
  - in_ready=0, out_valid=0, out_data=0, busy=0.
  - After deassertion, in_ready rises on the first clk edge.
- LOAD_KER:
  - in_ready=1. Each handshake (in_valid&&in_ready) writes byte k (k=0..8, row-major) into ker_flat.
  - After byte 8: ker_loaded=1, go to LOAD_TILE, count=0.
- LOAD_TILE:
  - in_ready=1. Each handshake writes byte k (k=0..15, row-major) into tile_flat.
  - After byte 15: go to COMPUTE, in_ready=0.
- COMPUTE:
  - tile_flat and ker_flat held constant.
  - After COMPUTE_WAIT cycles, conv_res is registered into the four result regs; go to DRAIN.
  - Default: last tile byte accepted at edge N, capture at edge N+2, out_valid high after edge N+2.
- DRAIN:
  - out_valid=1; out_data = result[idx], order out10, out11, out20, out21.
  - idx advances on out_valid&&out_ready. out_data stays stable while out_ready=0.
  - On the 4th handshake: out_valid=0, idx=0. Next state is LOAD_KER if ker_reload=1 or ker_loaded=0, else LOAD_TILE.
- Kernel retention: retained across frames. Tile registers are overwritten byte by byte during the next load.
- in_ready is 0 in COMPUTE and DRAIN; no input is accepted while results are pending.
- Result arithmetic is the engine's 8-bit truncation (modulo 256). This block does not widen or saturate.
- Reset mid-operation: all state is discarded. Partial kernel/tile and undrained results are lost. ker_loaded=0, so the next frame reloads the kernel.
- Counters never wrap silently: each state exits exactly at its terminal count.

Optional Feature:
- Macro: CNN_STREAM_OUT_LAST_EN.
- Defined:
  - Adds output port out_last (1 bit), high together with out_valid while idx=3 (out21), else 0. Reset 0.
  - Adds output port frame_done, a one-cycle pulse on the 4th DRAIN handshake.
- Undefined: neither port exists; behaviour otherwise identical.

Test Plan:
- Reset, then stream kernel 9x0x01 and tile 1..16 with in_valid held 1 and out_ready=1 → outputs 54, 63, 90, 99 in order; out_valid first high 2 cycles after the last tile byte.
- Kernel centre-only (byte 4=1, others 0), tile 1..16, ker_reload=0 on the next frame, new tile 17..32 with no kernel bytes → frame 1 outputs 6, 7, 10, 11; frame 2 outputs 22, 23, 26, 27.
- Kernel and tile all 0xFF → each output 9 (585225 mod 256).
- DRAIN with out_ready toggling 1-0-0-1 → out_data held through stalls; exactly 4 handshakes; in_ready=0 throughout.
- Assert rst_n=0 after tile byte 7 → all outputs 0 immediately. After release, the first 9 bytes load the kernel (ker_loaded cleared).
- Macro defined, run the first scenario → out_last high only with out21 (99); frame_done pulses once.
